cp0_exc_sequencer: RTL and testbench
====================================

// Module: cp0_exc_sequencer
// PURPOSE
//  Sequences exception entry and ERET return around the CP0 register block.
//  - Sits after MEM. Arbitrates the enabled interrupt, the synchronous exception and ERET.
//  - Drives the CP0 write port through a fixed multi-cycle sequence.
//  - Flushes and stalls the pipeline, then issues the redirect PC.
// PARAMETERS
//  EXC_VECTOR   32'h0000_0020  redirect target for every exception/interrupt
//  ADDR_STATUS  5'd12          CP0 Status register address
//  ADDR_CAUSE   5'd13          CP0 Cause register address
//  ADDR_EPC     5'd14          CP0 EPC register address
// PORTS
//  clk             in   1   clock (all state on rising edge)
//  rst             in   1   reset, asynchronous, active-low
//  instr_valid_i   in   1   MEM-stage instruction valid this cycle
//  exc_req_i       in   1   MEM-stage synchronous exception pending
//  exc_code_i      in   5   ExcCode of that exception
//  eret_i          in   1   MEM-stage instruction is ERET
//  pc_i            in   32  MEM-stage PC
//  in_delayslot_i  in   1   MEM-stage instruction is in a branch delay slot
//  status_i        in   32  current CP0 Status
//  cause_i         in   32  current CP0 Cause
//  epc_i           in   32  current CP0 EPC
//  cp0_we_o        out  1   CP0 write enable
//  cp0_waddr_o     out  5   CP0 write address
//  cp0_wdata_o     out  32  CP0 write data (full word; CP0 honours all Cause fields on this port)
//  flush_o         out  1   kill all pipeline stages, 1-cycle pulse
//  stall_o         out  1   hold IF..MEM while sequencing
//  new_pc_valid_o  out  1   redirect strobe, 1-cycle pulse
//  new_pc_o        out  32  redirect target, valid with new_pc_valid_o
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; capture regs 0.
//  - int_pend = status_i[0] & ~status_i[1] & |(cause_i[15:8] & status_i[15:8]).
//  - IDLE accepts an event only when instr_valid_i=1. Priority: int_pend > exc_req_i > eret_i.
//  - On accept, the same cycle: flush_o=1, stall_o=1. Capture:
//    - pc_i, in_delayslot_i and status_i
//    - code: 0 for interrupt, exc_code_i otherwise
//    - keep_epc = status_i[1] (EXL already set)
//    - eret_pc = epc_i for ERET
//  - Exception path: IDLE->WR_EPC->WR_CAUSE->WR_STATUS->REDIRECT->IDLE.
//    - WR_EPC: we=1, addr=ADDR_EPC, data = bd ? pc-32'd4 : pc.
//      If keep_epc: we=0 (slot still consumed).
//    - WR_CAUSE: addr=ADDR_CAUSE, data = cause_i with [31]=bd, [6:2]=code.
//      Live cause_i is used, so IP bits stay current.
//    - WR_STATUS: addr=ADDR_STATUS, data = captured status | 32'h2 (set EXL).
//    - REDIRECT: new_pc_valid_o=1, new_pc_o=EXC_VECTOR.
//  - ERET path: IDLE->WR_STATUS->REDIRECT->IDLE.
//    - WR_STATUS: data = captured status & ~32'h2.
//    - REDIRECT: new_pc_o = eret_pc.
//  - stall_o=1 in every non-IDLE state and in the accept cycle; it drops the cycle after REDIRECT.
//  - Latency accept->redirect: 4 cycles (exception), 2 cycles (ERET).
//  - Inputs are ignored while not IDLE; events arriving then are flushed and never serviced.
//  - Simultaneous int_pend and exc_req_i: the interrupt wins; the synchronous exception is
//    discarded and re-raises on re-execution.
//  - pc-4 wraps modulo 2^32 (pc=0 gives EPC 32'hFFFF_FFFC).
//  - Reset asserted mid-sequence: immediate return to IDLE, outputs 0, no partial write completes.
//  - cp0_waddr_o/cp0_wdata_o are 0 whenever cp0_we_o=0.
// CONFIGURATION
//  CP0_SEQ_TIMER_INT_EN:
//    - Defined: adds port timer_int_i (in, 1); pending IP7 = cause_i[15] | timer_int_i,
//      still masked by status_i[15].
//    - Undefined: port absent; pending bits come from cause_i[15:8] only.
// TESTING
//  1 exc_req_i=1, code=5'd12, pc=0x100, bd=0, Status=0x1000_0001 -> flush same cycle;
//    EPC<=0x100, Cause[6:2]=12, Status<=0x1000_0003; redirect 0x20 at cycle 4.
//  2 Same with bd=1, pc=0x204 -> EPC<=0x200, Cause[31]=1.
//  3 Status=0x1000_0401, Cause[10]=1, exc_req_i=1 same cycle -> interrupt taken:
//    Cause[6:2]=0, no second sequence.
//  4 Status EXL=1, exc_req_i=1 -> no EPC write; Cause and Status still written; redirect 0x20.
//  5 eret_i=1, EPC=0x400, Status=0x1000_0003 -> Status<=0x1000_0001; redirect 0x400 at cycle 2;
//    no EPC/Cause writes.
//  6 rst low during WR_CAUSE -> outputs 0 asynchronously; after release, IDLE accepts a new exception.

Source files
------------

// File: rtl/cp0_exc_sequencer_if.sv
// CP0 exception sequencer bus: MEM-stage event inputs, live CP0 register
// values, the CP0 write port and the pipeline flush/stall/redirect controls.
// The sequencer connects as slave; the pipeline/CP0 side connects as master.
interface cp0_exc_sequencer_if;
  logic        instr_valid_i;
  logic        exc_req_i;
  logic [4:0]  exc_code_i;
  logic        eret_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;

  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_wdata_o;
  logic        flush_o;
  logic        stall_o;
  logic        new_pc_valid_o;
  logic [31:0] new_pc_o;

  modport slave (
    input  instr_valid_i, exc_req_i, exc_code_i, eret_i, pc_i, in_delayslot_i,
           status_i, cause_i, epc_i,
    output cp0_we_o, cp0_waddr_o, cp0_wdata_o, flush_o, stall_o,
           new_pc_valid_o, new_pc_o
  );

  modport master (
    output instr_valid_i, exc_req_i, exc_code_i, eret_i, pc_i, in_delayslot_i,
           status_i, cause_i, epc_i,
    input  cp0_we_o, cp0_waddr_o, cp0_wdata_o, flush_o, stall_o,
           new_pc_valid_o, new_pc_o
  );
endinterface

// File: rtl/cp0_exc_sequencer.sv
// CP0 exception/ERET sequencer. Accepts one event from the MEM stage, flushes
// the pipeline, walks the CP0 write port through EPC/Cause/Status (exception)
// or Status only (ERET), then issues the redirect PC.
// Optional feature macro: CP0_SEQ_TIMER_INT_EN adds timer_int_i, ORed into IP7.
module cp0_exc_sequencer #(
  parameter logic [31:0] EXC_VECTOR  = 32'h0000_0020,
  parameter logic [4:0]  ADDR_STATUS = 5'd12,
  parameter logic [4:0]  ADDR_CAUSE  = 5'd13,
  parameter logic [4:0]  ADDR_EPC    = 5'd14
) (
  input logic                clk,
  input logic                rst,
`ifdef CP0_SEQ_TIMER_INT_EN
  input logic                timer_int_i,
`endif
  cp0_exc_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_EPC    = 3'd1;
  localparam logic [2:0] S_WR_CAUSE  = 3'd2;
  localparam logic [2:0] S_WR_STATUS = 3'd3;
  localparam logic [2:0] S_REDIRECT  = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] status_q, status_d;
  logic [31:0] eret_pc_q, eret_pc_d;
  logic [4:0]  code_q, code_d;
  logic        bd_q, bd_d;
  logic        keep_epc_q, keep_epc_d;
  logic        is_eret_q, is_eret_d;

  logic [7:0]  pend_bits;
  logic        int_pend;
  logic        take_exc;
  logic        accept;

  // Pending interrupt lines, optionally with the timer folded into IP7.
`ifdef CP0_SEQ_TIMER_INT_EN
  assign pend_bits = {bus.cause_i[15] | timer_int_i, bus.cause_i[14:8]};
`else
  assign pend_bits = bus.cause_i[15:8];
`endif

  assign int_pend = bus.status_i[0] & ~bus.status_i[1] &
                    (|(pend_bits & bus.status_i[15:8]));
  assign take_exc = int_pend | bus.exc_req_i;
  // Gated by rst so nothing leaks out while reset is held.
  assign accept   = rst & (state_q == S_IDLE) & bus.instr_valid_i &
                    (take_exc | bus.eret_i);

  // Next state and event capture.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    status_d   = status_q;
    eret_pc_d  = eret_pc_q;
    code_d     = code_q;
    bd_d       = bd_q;
    keep_epc_d = keep_epc_q;
    is_eret_d  = is_eret_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d    = take_exc ? S_WR_EPC : S_WR_STATUS;
          pc_d       = bus.pc_i;
          status_d   = bus.status_i;
          eret_pc_d  = bus.epc_i;
          code_d     = int_pend ? 5'd0 : bus.exc_code_i;
          bd_d       = bus.in_delayslot_i;
          keep_epc_d = bus.status_i[1];
          is_eret_d  = ~take_exc;
        end
      end
      S_WR_EPC:    state_d = S_WR_CAUSE;
      S_WR_CAUSE:  state_d = S_WR_STATUS;
      S_WR_STATUS: state_d = S_REDIRECT;
      S_REDIRECT:  state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // State and capture registers; reset drops any sequence in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      pc_q       <= 32'd0;
      status_q   <= 32'd0;
      eret_pc_q  <= 32'd0;
      code_q     <= 5'd0;
      bd_q       <= 1'b0;
      keep_epc_q <= 1'b0;
      is_eret_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      status_q   <= status_d;
      eret_pc_q  <= eret_pc_d;
      code_q     <= code_d;
      bd_q       <= bd_d;
      keep_epc_q <= keep_epc_d;
      is_eret_q  <= is_eret_d;
    end
  end

  // Output decode; write address/data stay 0 whenever the write enable is low.
  always_comb begin
    bus.cp0_we_o       = 1'b0;
    bus.cp0_waddr_o    = 5'd0;
    bus.cp0_wdata_o    = 32'd0;
    bus.flush_o        = accept;
    bus.stall_o        = accept | (state_q != S_IDLE);
    bus.new_pc_valid_o = 1'b0;
    bus.new_pc_o       = 32'd0;
    case (state_q)
      S_WR_EPC: begin
        // With EXL already set the original EPC is preserved; the slot is still spent.
        if (!keep_epc_q) begin
          bus.cp0_we_o    = 1'b1;
          bus.cp0_waddr_o = ADDR_EPC;
          bus.cp0_wdata_o = bd_q ? (pc_q - 32'd4) : pc_q;
        end
      end
      S_WR_CAUSE: begin
        // Live Cause keeps the IP bits current; only BD and ExcCode are replaced.
        bus.cp0_we_o    = 1'b1;
        bus.cp0_waddr_o = ADDR_CAUSE;
        bus.cp0_wdata_o = {bd_q, bus.cause_i[30:7], code_q, bus.cause_i[1:0]};
      end
      S_WR_STATUS: begin
        bus.cp0_we_o    = 1'b1;
        bus.cp0_waddr_o = ADDR_STATUS;
        bus.cp0_wdata_o = is_eret_q ? (status_q & ~32'h2) : (status_q | 32'h2);
      end
      S_REDIRECT: begin
        bus.new_pc_valid_o = 1'b1;
        bus.new_pc_o       = is_eret_q ? eret_pc_q : EXC_VECTOR;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_sequencer.sv
// Scoreboard bench for cp0_exc_sequencer: each scenario pushes the CP0 writes
// and redirect it expects (with absolute cycle numbers) and a monitor pops and
// compares them as the DUT produces them.
module tb_cp0_exc_sequencer;

  localparam logic [4:0] A_STATUS = 5'd12;
  localparam logic [4:0] A_CAUSE  = 5'd13;
  localparam logic [4:0] A_EPC    = 5'd14;

  typedef struct {
    bit          redir;
    logic [4:0]  addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  cp0_exc_sequencer_if bus();

`ifdef CP0_SEQ_TIMER_INT_EN
  logic timer_int = 1'b0;
  cp0_exc_sequencer dut (.clk(clk), .rst(rst), .timer_int_i(timer_int), .bus(bus));
`else
  cp0_exc_sequencer dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every write/redirect must match the head of the scoreboard.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst === 1'b1) begin
      if (bus.cp0_we_o === 1'b1 || bus.new_pc_valid_o === 1'b1) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_output cyc=%0d: got we=%b addr=%0d data=%h redir=%b pc=%h, required no output",
                   cyc, bus.cp0_we_o, bus.cp0_waddr_o, bus.cp0_wdata_o, bus.new_pc_valid_o, bus.new_pc_o);
        end else begin
          e = sb.pop_front();
          if (bus.new_pc_valid_o !== e.redir || bus.cp0_we_o !== !e.redir || cyc != e.cyc ||
              (e.redir ? (bus.new_pc_o !== e.data)
                       : (bus.cp0_waddr_o !== e.addr || bus.cp0_wdata_o !== e.data))) begin
            n_fail++;
            $display("FAIL scoreboard cyc=%0d: got we=%b addr=%0d data=%h redir=%b pc=%h, required cyc=%0d redir=%b addr=%0d data=%h",
                     cyc, bus.cp0_we_o, bus.cp0_waddr_o, bus.cp0_wdata_o, bus.new_pc_valid_o,
                     bus.new_pc_o, e.cyc, e.redir, e.addr, e.data);
          end
        end
      end else begin
        n_checks++;
        if (bus.cp0_waddr_o !== 5'd0 || bus.cp0_wdata_o !== 32'd0) begin
          n_fail++;
          $display("FAIL idle_port_zero cyc=%0d: got addr=%0d data=%h, required 0/0",
                   cyc, bus.cp0_waddr_o, bus.cp0_wdata_o);
        end
      end
    end
  end

  function automatic logic [31:0] exp_cause(input logic [31:0] c, input logic bd,
                                            input logic [4:0] code);
    logic [31:0] r;
    r      = c;
    r[31]  = bd;
    r[6:2] = code;
    return r;
  endfunction

  task automatic push_wr(input logic [4:0] a, input logic [31:0] d, input int c);
    exp_t e;
    e.redir = 1'b0; e.addr = a; e.data = d; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic push_redir(input logic [31:0] pc, input int c);
    exp_t e;
    e.redir = 1'b1; e.addr = 5'd0; e.data = pc; e.cyc = c;
    sb.push_back(e);
  endtask

  task automatic set_inputs(input logic iv, input logic exc, input logic [4:0] code,
                            input logic eret, input logic [31:0] pc, input logic bd,
                            input logic [31:0] st, input logic [31:0] ca, input logic [31:0] ep);
    bus.instr_valid_i  = iv;
    bus.exc_req_i      = exc;
    bus.exc_code_i     = code;
    bus.eret_i         = eret;
    bus.pc_i           = pc;
    bus.in_delayslot_i = bd;
    bus.status_i       = st;
    bus.cause_i        = ca;
    bus.epc_i          = ep;
  endtask

  task automatic clear_ev();
    bus.instr_valid_i = 1'b0;
    bus.exc_req_i     = 1'b0;
    bus.eret_i        = 1'b0;
  endtask

  // Drives an event just after a rising edge; returns the accept cycle number.
  task automatic start_event(input logic exc, input logic [4:0] code, input logic eret,
                             input logic [31:0] pc, input logic bd, input logic [31:0] st,
                             input logic [31:0] ca, input logic [31:0] ep, output int a);
    @(posedge clk); #1;
    set_inputs(1'b1, exc, code, eret, pc, bd, st, ca, ep);
    a = cyc;
  endtask

  task automatic drain(input string name);
    repeat (6) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL %s_pending: got %0d outstanding expected outputs, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    set_inputs(1'b1, 1'b1, 5'd12, 1'b0, 32'h100, 1'b0, 32'h1000_0001, 32'h0, 32'h0);
    #1;
    n_checks++;
    if ({bus.cp0_we_o, bus.flush_o, bus.stall_o, bus.new_pc_valid_o} !== 4'b0 ||
        bus.cp0_waddr_o !== 5'd0 || bus.cp0_wdata_o !== 32'd0 || bus.new_pc_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b flush=%b stall=%b redir=%b, required all 0",
               bus.cp0_we_o, bus.flush_o, bus.stall_o, bus.new_pc_valid_o);
    end
    repeat (2) @(negedge clk);
    clear_ev();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.stall_o !== 1'b0 || bus.flush_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got stall=%b flush=%b, required 0/0", bus.stall_o, bus.flush_o);
    end
  endtask

  task automatic test_exception();
    int a;
    start_event(1'b1, 5'd12, 1'b0, 32'h100, 1'b0, 32'h1000_0001, 32'h0000_0300, 32'h0, a);
    push_wr(A_EPC, 32'h100, a + 1);
    push_wr(A_CAUSE, exp_cause(32'h0000_0300, 1'b0, 5'd12), a + 2);
    push_wr(A_STATUS, 32'h1000_0003, a + 3);
    push_redir(32'h20, a + 4);
    @(negedge clk);
    n_checks++;
    if (bus.flush_o !== 1'b1 || bus.stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL exc_accept: got flush=%b stall=%b, required 1/1", bus.flush_o, bus.stall_o);
    end
    @(posedge clk); #1;
    clear_ev();
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (bus.stall_o !== (k <= 4) || bus.flush_o !== 1'b0) begin
        n_fail++;
        $display("FAIL exc_stall_k%0d: got stall=%b flush=%b, required stall=%b flush=0",
                 k, bus.stall_o, bus.flush_o, (k <= 4));
      end
    end
    drain("exception");
  endtask

  task automatic test_delayslot();
    int a;
    start_event(1'b1, 5'd12, 1'b0, 32'h204, 1'b1, 32'h1000_0001, 32'h0000_0300, 32'h0, a);
    push_wr(A_EPC, 32'h200, a + 1);
    push_wr(A_CAUSE, exp_cause(32'h0000_0300, 1'b1, 5'd12), a + 2);
    push_wr(A_STATUS, 32'h1000_0003, a + 3);
    push_redir(32'h20, a + 4);
    @(posedge clk); #1;
    clear_ev();
    drain("delayslot");
  endtask

  task automatic test_interrupt();
    int a;
    start_event(1'b1, 5'd12, 1'b0, 32'h180, 1'b0, 32'h1000_0401, 32'h0000_0400, 32'h0, a);
    push_wr(A_EPC, 32'h180, a + 1);
    push_wr(A_CAUSE, exp_cause(32'h0000_0400, 1'b0, 5'd0), a + 2);
    push_wr(A_STATUS, 32'h1000_0403, a + 3);
    push_redir(32'h20, a + 4);
    @(negedge clk);
    n_checks++;
    if (bus.flush_o !== 1'b1) begin
      n_fail++;
      $display("FAIL int_accept: got flush=%b, required 1", bus.flush_o);
    end
    @(posedge clk); #1;
    clear_ev();
    drain("interrupt");
  endtask

  task automatic test_exl();
    int a;
    start_event(1'b1, 5'd4, 1'b0, 32'h300, 1'b0, 32'h1000_0003, 32'h0000_0400, 32'h0, a);
    push_wr(A_CAUSE, exp_cause(32'h0000_0400, 1'b0, 5'd4), a + 2);
    push_wr(A_STATUS, 32'h1000_0003, a + 3);
    push_redir(32'h20, a + 4);
    @(posedge clk); #1;
    clear_ev();
    drain("exl");
  endtask

  task automatic test_eret();
    int a;
    start_event(1'b0, 5'd0, 1'b1, 32'h380, 1'b0, 32'h1000_0003, 32'h0, 32'h400, a);
    push_wr(A_STATUS, 32'h1000_0001, a + 1);
    push_redir(32'h400, a + 2);
    @(negedge clk);
    n_checks++;
    if (bus.flush_o !== 1'b1 || bus.stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL eret_accept: got flush=%b stall=%b, required 1/1", bus.flush_o, bus.stall_o);
    end
    @(posedge clk); #1;
    clear_ev();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (bus.stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL eret_stall_drop: got stall=%b, required 0", bus.stall_o);
    end
    drain("eret");
  endtask

  task automatic test_pc_wrap();
    int a;
    start_event(1'b1, 5'd10, 1'b0, 32'h0, 1'b1, 32'h0000_0001, 32'h0, 32'h0, a);
    push_wr(A_EPC, 32'hFFFF_FFFC, a + 1);
    push_wr(A_CAUSE, exp_cause(32'h0, 1'b1, 5'd10), a + 2);
    push_wr(A_STATUS, 32'h0000_0003, a + 3);
    push_redir(32'h20, a + 4);
    @(posedge clk); #1;
    clear_ev();
    drain("pc_wrap");
  endtask

  task automatic test_back_to_back();
    int a;
    start_event(1'b1, 5'd12, 1'b0, 32'h500, 1'b0, 32'h1000_0001, 32'h0, 32'h0, a);
    push_wr(A_EPC, 32'h500, a + 1);
    push_wr(A_CAUSE, exp_cause(32'h0, 1'b0, 5'd12), a + 2);
    push_wr(A_STATUS, 32'h1000_0003, a + 3);
    push_redir(32'h20, a + 4);
    // Conflicting events held while busy must be ignored.
    @(posedge clk); #1;
    set_inputs(1'b1, 1'b1, 5'd9, 1'b1, 32'h600, 1'b1, 32'h1000_0001, 32'h0, 32'h700);
    repeat (3) @(posedge clk);
    #1;
    // ERET presented during REDIRECT is taken on the first IDLE cycle.
    set_inputs(1'b1, 1'b0, 5'd0, 1'b1, 32'h580, 1'b0, 32'h1000_0003, 32'h0, 32'h540);
    push_wr(A_STATUS, 32'h1000_0001, a + 6);
    push_redir(32'h540, a + 7);
    @(negedge clk);
    n_checks++;
    if (bus.flush_o !== 1'b0 || bus.stall_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_busy_ignore: got flush=%b stall=%b, required 0/1", bus.flush_o, bus.stall_o);
    end
    @(negedge clk);
    n_checks++;
    if (bus.flush_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_second_accept: got flush=%b, required 1", bus.flush_o);
    end
    @(posedge clk); #1;
    clear_ev();
    drain("back_to_back");
  endtask

  task automatic test_reset_mid();
    int a;
    start_event(1'b1, 5'd12, 1'b0, 32'h100, 1'b0, 32'h1000_0001, 32'h0, 32'h0, a);
    push_wr(A_EPC, 32'h100, a + 1);
    @(posedge clk); #1;
    clear_ev();
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.cp0_we_o, bus.flush_o, bus.stall_o, bus.new_pc_valid_o} !== 4'b0 ||
        bus.cp0_waddr_o !== 5'd0 || bus.cp0_wdata_o !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_mid_async: got we=%b addr=%0d data=%h stall=%b, required all 0",
               bus.cp0_we_o, bus.cp0_waddr_o, bus.cp0_wdata_o, bus.stall_o);
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_epc: got %0d outstanding, required 0", sb.size());
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_idle: got stall=%b, required 0", bus.stall_o);
    end
    start_event(1'b1, 5'd8, 1'b0, 32'h140, 1'b0, 32'h1000_0001, 32'h0, 32'h0, a);
    push_wr(A_EPC, 32'h140, a + 1);
    push_wr(A_CAUSE, exp_cause(32'h0, 1'b0, 5'd8), a + 2);
    push_wr(A_STATUS, 32'h1000_0003, a + 3);
    push_redir(32'h20, a + 4);
    @(posedge clk); #1;
    clear_ev();
    drain("reset_mid");
  endtask

  initial begin
    set_inputs(1'b0, 1'b0, 5'd0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 32'h0);
    test_reset();
    test_exception();
    test_delayslot();
    test_interrupt();
    test_exl();
    test_eret();
    test_pc_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
